// File: rtl/complex_mac_pkg.sv
// Shared types and width helpers for the complex multiply / multiply-accumulate pipe.
// Optional feature macro used by the pipe: COMPLEX_MAC_CONJ_EN (per-beat A*conj(B)).
package complex_mac_pkg;

    // Default operand component width; the pipe itself is parametrised.
    localparam int DEF_DATA_W = 8;

    // Width of one real/imag component of a single product: never wraps.
    function automatic int prod_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

    // Width of one output component: product plus headroom for a full frame.
    function automatic int out_w(input int data_w, input int acc_len);
        return prod_w(data_w) + $clog2(acc_len);
    endfunction

    // Packed {real, imag} operand at the default component width.
    typedef struct packed {
        logic signed [DEF_DATA_W-1:0] re;
        logic signed [DEF_DATA_W-1:0] im;
    } cplx_t;

    // Control carried alongside the data through each pipe stage.
    typedef struct packed {
        logic valid;
        logic acc;
        logic conj;
    } stage_t;

endpackage

// File: rtl/complex_mult_core.sv
// S1-S3 of the complex multiplier: operand register, four partial products,
// then real/imag combination at full product width. Every stage holds while
// stall is high. COMPLEX_MAC_CONJ_EN adds the per-beat conjugate of B.
module complex_mult_core
    import complex_mac_pkg::*;
#(
    parameter int DATA_W = 8,
    localparam int PROD_W = prod_w(DATA_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     in_valid,
    input  logic [2*DATA_W-1:0]      in_a,
    input  logic [2*DATA_W-1:0]      in_b,
    input  logic                     in_acc,
`ifdef COMPLEX_MAC_CONJ_EN
    input  logic                     in_conj,
`endif
    output logic                     out_valid,
    output logic                     out_acc,
    output logic signed [PROD_W-1:0] out_re,
    output logic signed [PROD_W-1:0] out_im
);

    localparam int MUL_W = 2 * DATA_W;

    stage_t s1_d, s1_q, s2_d, s2_q, s3_d, s3_q;
    logic [2*DATA_W-1:0] a_d, a_q, b_d, b_q;
    logic signed [MUL_W-1:0] rr_d, rr_q, ii_d, ii_q, ri_d, ri_q, ir_d, ir_q;
    logic signed [PROD_W-1:0] re_d, re_q, im_d, im_q;
    logic conj_in;

`ifdef COMPLEX_MAC_CONJ_EN
    assign conj_in = in_conj;
`else
    assign conj_in = 1'b0;
`endif

    logic signed [DATA_W-1:0] ar, ai, br, bi;
    assign ar = a_q[2*DATA_W-1:DATA_W];
    assign ai = a_q[DATA_W-1:0];
    assign br = b_q[2*DATA_W-1:DATA_W];
    assign bi = b_q[DATA_W-1:0];

    logic signed [MUL_W-1:0] rr, ii, ri, ir;
    assign rr = MUL_W'(ar) * MUL_W'(br);
    assign ii = MUL_W'(ai) * MUL_W'(bi);
    assign ri = MUL_W'(ar) * MUL_W'(bi);
    assign ir = MUL_W'(ai) * MUL_W'(br);

    // The conjugate flag is spent in S2 and only rides along afterwards.
    logic unused_conj;
    assign unused_conj = s3_q.conj;

    // S1: capture the operands and control of an accepted beat.
    always_comb begin
        s1_d = s1_q;
        a_d  = a_q;
        b_d  = b_q;
        if (!stall) begin
            s1_d.valid = in_valid;
            s1_d.acc   = in_acc;
            s1_d.conj  = conj_in;
            a_d        = in_a;
            b_d        = in_b;
        end
    end

    // S2: partial products; conj(B) negates the two terms that use bi, done on
    // the products so that negating the most negative bi cannot wrap.
    always_comb begin
        s2_d = s2_q;
        rr_d = rr_q;
        ii_d = ii_q;
        ri_d = ri_q;
        ir_d = ir_q;
        if (!stall) begin
            s2_d = s1_q;
            rr_d = rr;
            ir_d = ir;
`ifdef COMPLEX_MAC_CONJ_EN
            ii_d = s1_q.conj ? -ii : ii;
            ri_d = s1_q.conj ? -ri : ri;
`else
            ii_d = ii;
            ri_d = ri;
`endif
        end
    end

    // S3: combine at PROD_W after sign extension so the sum cannot wrap.
    always_comb begin
        s3_d = s3_q;
        re_d = re_q;
        im_d = im_q;
        if (!stall) begin
            s3_d = s2_q;
            re_d = $signed({rr_q[MUL_W-1], rr_q}) - $signed({ii_q[MUL_W-1], ii_q});
            im_d = $signed({ri_q[MUL_W-1], ri_q}) + $signed({ir_q[MUL_W-1], ir_q});
        end
    end

    // Pipe registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            rr_q <= '0;
            ii_q <= '0;
            ri_q <= '0;
            ir_q <= '0;
            re_q <= '0;
            im_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
            a_q  <= a_d;
            b_q  <= b_d;
            rr_q <= rr_d;
            ii_q <= ii_d;
            ri_q <= ri_d;
            ir_q <= ir_d;
            re_q <= re_d;
            im_q <= im_d;
        end
    end

    assign out_valid = s3_q.valid;
    assign out_acc   = s3_q.acc;
    assign out_re    = re_q;
    assign out_im    = im_q;

endmodule

// File: rtl/complex_mac_pipe.sv
// Complex multiply / multiply-accumulate pipe: S1-S3 core plus an output stage
// holding the frame accumulator, frame counter and result register.
// Optional feature macro: COMPLEX_MAC_CONJ_EN (adds InConj, A*conj(B) per beat).
//
// Handshake: a beat moves on InValid&&InReady, a result on OutValid&&OutReady.
// Stall = OutValid&&!OutReady; InReady = !stall combinationally, and while
// stalled every stage, OutResult and OutLast hold.
module complex_mac_pipe
    import complex_mac_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ACC_LEN = 16,
    localparam int PROD_W = prod_w(DATA_W),
    localparam int OUT_W  = out_w(DATA_W, ACC_LEN)
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                InValid,
    output logic                InReady,
    input  logic [2*DATA_W-1:0] InA,
    input  logic [2*DATA_W-1:0] InB,
    input  logic                InAcc,
`ifdef COMPLEX_MAC_CONJ_EN
    input  logic                InConj,
`endif
    output logic                OutValid,
    input  logic                OutReady,
    output logic [2*OUT_W-1:0]  OutResult,
    output logic                OutLast
);

    localparam int CNT_W = $clog2(ACC_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

    logic stall;
    logic s3_valid, s3_acc;
    logic signed [PROD_W-1:0] s3_re, s3_im;
    logic signed [OUT_W-1:0] prod_re, prod_im;

    logic out_valid_d, out_valid_q, out_last_d, out_last_q;
    logic signed [OUT_W-1:0] out_re_d, out_re_q, out_im_d, out_im_q;
    logic signed [OUT_W-1:0] acc_re_d, acc_re_q, acc_im_d, acc_im_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign stall   = out_valid_q && !OutReady;
    assign InReady = !stall;

    complex_mult_core #(.DATA_W(DATA_W)) u_core (
        .clk      (Clk),
        .rst_n    (Reset),
        .stall    (stall),
        .in_valid (InValid),
        .in_a     (InA),
        .in_b     (InB),
        .in_acc   (InAcc),
`ifdef COMPLEX_MAC_CONJ_EN
        .in_conj  (InConj),
`endif
        .out_valid(s3_valid),
        .out_acc  (s3_acc),
        .out_re   (s3_re),
        .out_im   (s3_im)
    );

    assign prod_re = {{(OUT_W-PROD_W){s3_re[PROD_W-1]}}, s3_re};
    assign prod_im = {{(OUT_W-PROD_W){s3_im[PROD_W-1]}}, s3_im};

    // Output stage: pass plain products, fold frame beats into the accumulator
    // and emit the frame total on its last beat; reload with no bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        acc_re_d    = acc_re_q;
        acc_im_d    = acc_im_q;
        cnt_d       = cnt_q;
        if (!stall) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            if (s3_valid && !s3_acc) begin
                out_valid_d = 1'b1;
                out_re_d    = prod_re;
                out_im_d    = prod_im;
            end else if (s3_valid && (cnt_q == CNT_LAST)) begin
                out_valid_d = 1'b1;
                out_last_d  = 1'b1;
                out_re_d    = acc_re_q + prod_re;
                out_im_d    = acc_im_q + prod_im;
                acc_re_d    = '0;
                acc_im_d    = '0;
                cnt_d       = '0;
            end else if (s3_valid) begin
                acc_re_d    = acc_re_q + prod_re;
                acc_im_d    = acc_im_q + prod_im;
                cnt_d       = cnt_q + CNT_W'(1);
            end
        end
    end

    // Output, accumulator and counter registers; reset drops any partial frame.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            cnt_q       <= cnt_d;
        end
    end

    assign OutValid  = out_valid_q;
    assign OutLast   = out_last_q;
    assign OutResult = {out_re_q, out_im_q};

endmodule
